// File: rtl/micro_seq.sv
// Microprogram sequencer: fetches micro-ops from a synchronous control store, hands them to
// p_test and loads the resolved next address into the micro-PC. Optional counter: MICRO_SEQ_CNT_EN.
module micro_seq #(
  parameter int unsigned              CTRL_W    = 20,
  parameter int unsigned              UADDR_W   = 6,
  parameter logic [UADDR_W-1:0]       HALT_ADDR = 6'h3F
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [UADDR_W-1:0]           start_addr,
  input  logic                         stall,
  output logic                         rom_en,
  output logic [UADDR_W-1:0]           rom_addr,
  input  logic [CTRL_W+UADDR_W-1:0]    rom_data,
  output logic [CTRL_W+UADDR_W-1:0]    micro_op,
  output logic                         uop_valid,
  input  logic [CTRL_W+UADDR_W-1:0]    next_micro_op,
  output logic                         busy,
  output logic                         done,
  output logic [15:0]                  uop_count
);

  localparam int unsigned MICRO_W = CTRL_W + UADDR_W;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    EXEC  = 3'd3,
    TEST  = 3'd4
  } state_t;

  state_t               state;
  logic [UADDR_W-1:0]   upc;
  logic [MICRO_W-1:0]   uir;
  logic [UADDR_W-1:0]   next_addr;
  logic                 start_ok;
  logic                 unused_ctrl;

  // Only the resolved next-address field of p_test's output matters here.
  assign next_addr   = next_micro_op[UADDR_W-1:0];
  assign unused_ctrl = ^next_micro_op[MICRO_W-1:UADDR_W];
  assign start_ok    = (state == IDLE) && start;

  // micro_op mirrors uir in every state so p_test always registers a stable value.
  assign micro_op = uir;

  // done is valid in the TEST cycle itself, when p_test's registered result first appears.
  assign done = !rst && (state == TEST) && (next_addr == HALT_ADDR);

  // Sequencer FSM; rom_en/rom_addr/uop_valid/busy are registered against the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      upc       <= '0;
      uir       <= '0;
      rom_en    <= 1'b0;
      rom_addr  <= '0;
      uop_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rom_en    <= 1'b0;
      uop_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            upc      <= start_addr;
            rom_en   <= 1'b1;
            rom_addr <= start_addr;
            busy     <= 1'b1;
            state    <= FETCH;
          end
        end
        FETCH: begin
          state <= LOAD;
        end
        LOAD: begin
          uir       <= rom_data;
          uop_valid <= 1'b1;
          state     <= EXEC;
        end
        EXEC: begin
          if (stall) begin
            uop_valid <= 1'b1;
          end else begin
            state <= TEST;
          end
        end
        TEST: begin
          upc <= next_addr;
          if (next_addr == HALT_ADDR) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            rom_en   <= 1'b1;
            rom_addr <= next_addr;
            state    <= FETCH;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MICRO_SEQ_CNT_EN
  logic [15:0] cnt_q;

  // Executed micro-op count: one per TEST, saturating, cleared by an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (start_ok) begin
      cnt_q <= '0;
    end else if ((state == TEST) && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'(1);
    end
  end

  assign uop_count = cnt_q;
`else
  logic unused_start_ok;

  assign unused_start_ok = start_ok;
  assign uop_count       = 16'h0000;
`endif

endmodule
